fsqrt_ctrl: RTL and testbench
=============================

FSQRT_CTRL -- requirements
Module: fsqrt_ctrl

Interface
REQ-001 SHALL have parameter CORE_WAIT, default 13, meaning cycles spent in WAIT before capturing the core result.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand offered.
REQ-005 SHALL have port in_ready  output  1  operand accepted when in_valid&in_ready at an edge.
REQ-006 SHALL have port in_x  input  32  IEEE-754 single operand.
REQ-007 SHALL have port out_valid  output  1  result available.
REQ-008 SHALL have port out_ready  input  1  result consumed when out_valid&out_ready at an edge.
REQ-009 SHALL have port out_rslt  output  32  IEEE-754 single square root.
REQ-010 SHALL have port out_flag  output  5  exception flags {NV,DZ,OF,UF,NX}, bit4..bit0.
REQ-011 SHALL have port core_start  output  1  drives the iterative sqrt core's load/reset input, active-high.
REQ-012 SHALL have port core_x  output  32  operand to core; held stable from START through WAIT.
REQ-013 SHALL have port core_rslt  input  32  core result, valid 14 edges after core_start edge.
REQ-014 SHALL have port core_nx  input  1  core inexact indication.

Function
REQ-015 SHALL implement states IDLE, START, WAIT, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 IDLE, accept of special operand SHALL go to DONE with out_rslt/out_flag loaded at the accept edge (latency 1 edge).
REQ-018 IDLE, accept of normal positive operand SHALL latch in_x into core_x and go to START.
REQ-019 START SHALL last one cycle with core_start=1, then go to WAIT with counter loaded to CORE_WAIT.
REQ-020 WAIT SHALL decrement counter each cycle; at counter==1 the edge SHALL capture core_rslt into out_rslt, out_flag={4'b0,core_nx}, and go to DONE (normal latency 15 edges accept->out_valid).
REQ-021 core_start SHALL be 0 in every state except START.
REQ-022 DONE SHALL assert out_valid and hold out_rslt/out_flag stable until out_ready; handshake edge returns to IDLE.
REQ-023 out_valid SHALL be 0 in IDLE, START, WAIT.
REQ-024 Special cases: +0/-0 -> in_x, flags 0.
REQ-025 Denormal (exp=0, frac!=0) -> signed zero of in_x sign, flag NX.
REQ-026 +inf -> 0x7F800000, flags 0.
REQ-027 sNaN -> in_x|0x00400000, flag NV; qNaN -> in_x, flags 0.
REQ-028 Negative nonzero non-NaN (incl. -inf, negative denormal excluded per REQ-025) -> 0x7FC00000, flag NV.
REQ-029 in_valid while not IDLE SHALL be ignored; no operand lost or duplicated.
REQ-030 A DONE->IDLE edge SHALL NOT accept a new operand in the same cycle (in_ready low in DONE).

Reset
REQ-031 Reset low SHALL immediately force IDLE, counter 0, core_start 0, core_x 0, out_valid 0, out_rslt 0, out_flag 0, in_ready 1 after release.
REQ-032 Reset mid-WAIT SHALL abandon the operation; no out_valid after release until a new accept.

Structure
REQ-033 Shared package fsqrt_pkg SHALL hold state enum, QNAN_DEFAULT=0x7FC00000, PINF=0x7F800000, flag bit indices, CORE_WAIT default.
REQ-034 Classification SHALL live in combinational sub-module fsqrt_classify (in_x -> is_special, special_rslt, special_flag).
REQ-035 The sqrt core SHALL be instantiated beside, not inside, fsqrt_ctrl.

Verification
REQ-036 in_x=0x40800000 (4.0), core model returns 0x40000000 -> out_valid 15 edges after accept, out_rslt 0x40000000, flag 0.
REQ-037 in_x=0xBF800000 (-1.0) -> out_valid next edge, out_rslt 0x7FC00000, flag 0x10, core_start never asserted.
REQ-038 in_x=0x7F800001 (sNaN) -> out_rslt 0x7FC00001, flag 0x10; in_x=0x80000000 -> 0x80000000, flag 0.
REQ-039 Normal result with out_ready held 0 for 10 cycles -> out_rslt stable, in_ready 0 throughout, single transfer on release.
REQ-040 Reset asserted at WAIT counter 6 -> core_start 0, out_valid 0; next accept of 0x41100000 yields 0x40400000 at 15 edges.
REQ-041 in_valid held high continuously with alternating special/normal operands -> each result delivered once, in order.

Source files
------------

// File: rtl/fsqrt_pkg.sv
// Shared definitions for the single-precision square-root controller:
// FSM state encoding, IEEE-754 field layout, canonical result constants,
// exception flag bit positions and the default core wait length.
package fsqrt_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned FLAG_W            = 5;
  localparam int unsigned CORE_WAIT_DEFAULT = 13;

  // Exception flag bit positions within {NV,DZ,OF,UF,NX}
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam logic [XLEN-1:0] QNAN_DEFAULT = 32'h7FC0_0000;
  localparam logic [XLEN-1:0] PINF         = 32'h7F80_0000;
  localparam logic [XLEN-1:0] QUIET_BIT    = 32'h0040_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

endpackage

// File: rtl/fsqrt_classify.sv
// Combinational operand classifier. Decides whether an operand can be
// answered without the iterative core and, if so, what the result is.
//   in_x         : IEEE-754 single operand
//   is_special   : 1 unless the operand is a positive normal number
//   special_rslt : result for special operands
//   special_flag : exception flags {NV,DZ,OF,UF,NX} for special operands
module fsqrt_classify
  import fsqrt_pkg::*;
(
  input  logic [XLEN-1:0]   in_x,
  output logic              is_special,
  output logic [XLEN-1:0]   special_rslt,
  output logic [FLAG_W-1:0] special_flag
);

  fp32_t x;
  logic  exp_zero;
  logic  exp_ones;
  logic  frac_zero;

  assign x         = in_x;
  assign exp_zero  = (x.exp == 8'h00);
  assign exp_ones  = (x.exp == 8'hFF);
  assign frac_zero = (x.frac == 23'd0);

  // NaNs are tested first so a negative NaN is never turned into the default NaN
  always_comb begin
    is_special   = 1'b1;
    special_rslt = in_x;
    special_flag = '0;
    if (exp_ones && !frac_zero) begin
      if (!x.frac[22]) begin
        special_rslt          = in_x | QUIET_BIT;
        special_flag[FLAG_NV] = 1'b1;
      end
    end else if (exp_zero && frac_zero) begin
      special_rslt = in_x;
    end else if (exp_zero) begin
      // Denormals flush to a zero that keeps the operand sign
      special_rslt          = {x.sign, 31'd0};
      special_flag[FLAG_NX] = 1'b1;
    end else if (x.sign) begin
      special_rslt          = QNAN_DEFAULT;
      special_flag[FLAG_NV] = 1'b1;
    end else if (exp_ones) begin
      special_rslt = PINF;
    end else begin
      is_special = 1'b0;
    end
  end

endmodule

// File: rtl/fsqrt_ctrl.sv
// Handshake controller around an external iterative square-root core.
// Special operands are answered directly; positive normals are sent to
// the core, which is started for one cycle and sampled CORE_WAIT cycles later.
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake, in_x operand
//   out_valid/out_ready : result handshake, out_rslt result, out_flag flags
//   core_start, core_x  : core load pulse and held operand
//   core_rslt, core_nx  : core result and inexact indication
module fsqrt_ctrl
  import fsqrt_pkg::*;
#(
  parameter int unsigned CORE_WAIT = CORE_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rslt,
  output logic [FLAG_W-1:0] out_flag,
  output logic              core_start,
  output logic [XLEN-1:0]   core_x,
  input  logic [XLEN-1:0]   core_rslt,
  input  logic              core_nx
);

  localparam int unsigned CNT_W = (CORE_WAIT < 2) ? 1 : $clog2(CORE_WAIT + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     core_x_q, core_x_d;
  logic [XLEN-1:0]     rslt_q, rslt_d;
  logic [FLAG_W-1:0]   flag_q, flag_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                core_start_q, core_start_d;

  logic                cls_special;
  logic [XLEN-1:0]     cls_rslt;
  logic [FLAG_W-1:0]   cls_flag;

  fsqrt_classify u_classify (
    .in_x         (in_x),
    .is_special   (cls_special),
    .special_rslt (cls_rslt),
    .special_flag (cls_flag)
  );

  // Next-state and datapath load decisions
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    core_x_d = core_x_q;
    rslt_d   = rslt_q;
    flag_d   = flag_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (cls_special) begin
            rslt_d  = cls_rslt;
            flag_d  = cls_flag;
            state_d = ST_DONE;
          end else begin
            core_x_d = in_x;
            state_d  = ST_START;
          end
        end
      end
      ST_START: begin
        cnt_d   = CNT_W'(CORE_WAIT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rslt_d          = core_rslt;
          flag_d          = '0;
          flag_d[FLAG_NX] = core_nx;
          state_d         = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake and core strobes are registered copies of the next state
    in_ready_d   = (state_d == ST_IDLE);
    out_valid_d  = (state_d == ST_DONE);
    core_start_d = (state_d == ST_START);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      core_x_q     <= '0;
      rslt_q       <= '0;
      flag_q       <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_x_q     <= core_x_d;
      rslt_q       <= rslt_d;
      flag_q       <= flag_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      core_start_q <= core_start_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_rslt   = rslt_q;
  assign out_flag   = flag_q;
  assign core_start = core_start_q;
  assign core_x     = core_x_q;

endmodule

// File: tb/tb_fsqrt_ctrl.sv
// Self-checking bench for fsqrt_ctrl with a stand-in iterative core.
module tb_fsqrt_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rslt;
  logic [4:0]  out_flag;
  logic        core_start;
  logic [31:0] core_x;
  logic [31:0] core_rslt = 32'd0;
  logic        core_nx   = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fsqrt_ctrl #(.CORE_WAIT(13)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rslt   (out_rslt),
    .out_flag   (out_flag),
    .core_start (core_start),
    .core_x     (core_x),
    .core_rslt  (core_rslt),
    .core_nx    (core_nx)
  );

  // Stand-in core answer: exact roots for the directed operands, a hash otherwise
  function automatic logic [31:0] core_fn(input logic [31:0] x);
    case (x)
      32'h4080_0000: return 32'h4000_0000;
      32'h4110_0000: return 32'h4040_0000;
      default:       return x ^ 32'h1357_9BDF;
    endcase
  endfunction

  function automatic logic core_nx_fn(input logic [31:0] x);
    if (x == 32'h4080_0000 || x == 32'h4110_0000) return 1'b0;
    return ^x;
  endfunction

  // Core model: garbage until its result becomes valid 14 edges after the start rose
  int          core_cnt = 0;
  logic [31:0] core_lat_x = 32'd0;
  always @(posedge clk) begin
    if (core_start) begin
      core_lat_x <= core_x;
      core_cnt   <= 0;
      core_rslt  <= 32'hDEAD_BEEF;
      core_nx    <= 1'b0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 == 12) begin
        core_rslt <= core_fn(core_lat_x);
        core_nx   <= core_nx_fn(core_lat_x);
      end
    end
  end

  function automatic logic is_normal(input logic [31:0] x);
    logic [7:0] e;
    e = x[30:23];
    return (x[31] == 1'b0) && (e != 8'h00) && (e != 8'hFF);
  endfunction

  // Reference result {flag, rslt} from the IEEE square-root special-case rules
  function automatic logic [36:0] model(input logic [31:0] x);
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = x[31];
    e = x[30:23];
    f = x[22:0];
    if (e == 8'hFF && f != 23'd0) begin
      if (f[22]) return {5'h00, x};
      return {5'h10, x | 32'h0040_0000};
    end
    if (e == 8'h00 && f == 23'd0) return {5'h00, x};
    if (e == 8'h00) return {5'h01, s, 31'd0};
    if (s) return {5'h10, 32'h7FC0_0000};
    if (e == 8'hFF) return {5'h00, 32'h7F80_0000};
    return {4'd0, core_nx_fn(x), core_fn(x)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_normal();
    logic [31:0] r;
    r = $urandom;
    return {1'b0, 8'($urandom_range(1, 254)), r[22:0]};
  endfunction

  function automatic logic [31:0] rand_special();
    logic [31:0] r;
    logic        s;
    r = $urandom;
    s = r[31];
    case ($urandom_range(0, 7))
      0:       return {s, 31'd0};
      1:       return {s, 8'h00, r[22:0] | 23'd1};
      2:       return 32'h7F80_0000;
      3:       return 32'hFF80_0000;
      4:       return {s, 8'hFF, 1'b0, r[21:0] | 22'd1};
      5:       return {s, 8'hFF, 1'b1, r[21:0]};
      default: return {1'b1, 8'($urandom_range(1, 254)), r[22:0]};
    endcase
  endfunction

  // One operand end to end: latency, result, hold under back-pressure, release
  task automatic do_op(input logic [31:0] x, input int hold);
    logic [36:0] e;
    logic        nrm;
    int          lat;
    int          starts;
    e   = model(x);
    nrm = is_normal(x);
    in_x      = x;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_x     = 32'hFFFF_FFFF;
    lat      = 1;
    starts   = 0;
    while (!out_valid && lat < 40) begin
      starts += int'(core_start);
      tick();
      lat++;
    end
    chk("latency", 32'(lat), nrm ? 32'd15 : 32'd1);
    chk("core_start_cycles", 32'(starts), nrm ? 32'd1 : 32'd0);
    chk("out_rslt", out_rslt, e[31:0]);
    chk("out_flag", 32'(out_flag), 32'(e[36:32]));
    if (nrm) chk("core_x_held", core_x, x);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_x     = 32'hBF80_0000;
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_rslt", out_rslt, e[31:0]);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ops[30];
    int          idx;
    int          nout;
    int          cyc;
    int          extra;
    logic        acc;
    logic        dlv;
    logic        seen;
    logic [36:0] e;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_x      = 32'd0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_core_x", core_x, 32'd0);
    chk("rst_out_rslt", out_rslt, 32'd0);
    chk("rst_out_flag", 32'(out_flag), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed operands
    do_op(32'h4080_0000, 0);
    do_op(32'hBF80_0000, 0);
    do_op(32'h7F80_0001, 0);
    do_op(32'h8000_0000, 0);
    do_op(32'h4080_0000, 10);
    do_op(32'h0000_0000, 0);
    do_op(32'h7F80_0000, 0);
    do_op(32'hFF80_0000, 2);
    do_op(32'h0000_0001, 0);
    do_op(32'h8000_0005, 1);
    do_op(32'h7FC0_0000, 0);
    do_op(32'hFFC1_2345, 0);

    // Reset abandoned while the core is running
    in_x     = 32'h4080_0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    chk("mid_wait_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_core_start", 32'(core_start), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_core_x", core_x, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    seen  = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | out_valid;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    do_op(32'h4110_0000, 0);

    // Random single operations
    for (int i = 0; i < 16; i++) begin
      do_op(($urandom_range(0, 1) == 1) ? rand_normal() : rand_special(),
            $urandom_range(0, 3));
    end

    // Back-to-back stream, in_valid held high, alternating operand kinds
    for (int i = 0; i < 30; i++) ops[i] = (i % 2 == 0) ? rand_special() : rand_normal();
    idx  = 0;
    nout = 0;
    cyc  = 0;
    while (nout < 30 && cyc < 5000) begin
      in_valid  = (idx < 30);
      in_x      = (idx < 30) ? ops[idx] : 32'd0;
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid) chk("stream_ready_in_done", 32'(in_ready), 32'd0);
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv) begin
        e = model(ops[nout]);
        chk("stream_rslt", out_rslt, e[31:0]);
        chk("stream_flag", 32'(out_flag), 32'(e[36:32]));
        nout++;
      end
      tick();
      if (acc) idx++;
      cyc++;
    end
    chk("stream_delivered", 32'(nout), 32'd30);
    chk("stream_accepted", 32'(idx), 32'd30);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    extra     = 0;
    repeat (20) begin
      tick();
      extra += int'(out_valid);
    end
    chk("stream_no_extra", 32'(extra), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
